// File: rtl/period_tracker_if.sv
// Period stream from the oversampled frequency counter, together with the
// averaged timing results that go to the drive-timing and feedback logic.
interface period_tracker_if;
    logic        period_valid;
    logic [31:0] period;
    logic        avg_valid;
    logic [31:0] avg_period;
    logic [31:0] half_period;
    logic        locked;
    logic        timeout;
    logic [15:0] reject_count;

    // Upstream / consumer side: supplies periods and observes the results.
    modport master (
        output period_valid,
        output period,
        input  avg_valid,
        input  avg_period,
        input  half_period,
        input  locked,
        input  timeout,
        input  reject_count
    );

    // Tracker side: consumes periods and publishes the results.
    modport slave (
        input  period_valid,
        input  period,
        output avg_valid,
        output avg_period,
        output half_period,
        output locked,
        output timeout,
        output reject_count
    );
endinterface

// File: rtl/period_tracker.sv
// Moving-average period tracker. Accepts in-range periods (1/16-clock units),
// averages the last 2^AVG_LOG2 of them, reports lock when consecutive samples
// stay within TOL of the average, and signals loss of signal after
// TIMEOUT_CYCLES cycles without an accepted sample. AVG_LOG2 must be >= 1.
module period_tracker #(
    parameter int AVG_LOG2       = 3,
    parameter int MIN_PERIOD     = 32,
    parameter int MAX_PERIOD     = 65535,
    parameter int LOCK_COUNT     = 4,
    parameter int TOL            = 64,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic             clock,
    input  logic             reset,
    period_tracker_if.slave  bus
);
    localparam int DEPTH   = 1 << AVG_LOG2;
    localparam int SUM_W   = 32 + AVG_LOG2;
    localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
    localparam int TMO_W   = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [AVG_LOG2-1:0] PTR_ONE    = AVG_LOG2'(1);
    localparam logic [AVG_LOG2:0]   FILL_ONE   = (AVG_LOG2 + 1)'(1);
    localparam logic [AVG_LOG2:0]   FILL_LAST  = (AVG_LOG2 + 1)'(DEPTH - 1);
    localparam logic [MATCH_W-1:0]  MATCH_ONE  = MATCH_W'(1);
    localparam logic [MATCH_W-1:0]  MATCH_FULL = MATCH_W'(LOCK_COUNT);
    localparam logic [TMO_W-1:0]    TMO_ONE    = TMO_W'(1);
    localparam logic [TMO_W-1:0]    TMO_LAST   = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMO_W-1:0]    TMO_DONE   = TMO_W'(TIMEOUT_CYCLES);
    localparam logic [31:0]         MIN_P      = 32'(MIN_PERIOD);
    localparam logic [31:0]         MAX_P      = 32'(MAX_PERIOD);
    localparam logic [31:0]         TOL_P      = 32'(TOL);

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                state_r;
    logic [31:0]           buf_r [DEPTH];
    logic [AVG_LOG2-1:0]   wr_ptr_r;
    logic [AVG_LOG2:0]     fill_count_r;
    logic [SUM_W-1:0]      sum_r;
    logic [MATCH_W-1:0]    match_count_r;
    logic [TMO_W-1:0]      tmo_cnt_r;

    logic                  avg_valid_r;
    logic [31:0]           avg_period_r;
    logic [31:0]           half_period_r;
    logic                  locked_r;
    logic                  timeout_r;
    logic [15:0]           reject_count_r;

    logic                  accept_s;
    logic [31:0]           oldest_s;
    logic [SUM_W-1:0]      sum_next_s;
    logic [31:0]           avg_next_s;
    logic [31:0]           diff_s;
    logic [MATCH_W-1:0]    match_next_s;
    logic                  tmo_fire_s;

    assign accept_s   = bus.period_valid && (bus.period >= MIN_P) && (bus.period <= MAX_P);
    // While filling, the slot being overwritten holds stale data and counts as zero.
    assign oldest_s   = (state_r == ST_RUN) ? buf_r[wr_ptr_r] : 32'd0;
    assign sum_next_s = sum_r + SUM_W'(bus.period) - SUM_W'(oldest_s);
    assign avg_next_s = sum_next_s[AVG_LOG2 +: 32];
    assign tmo_fire_s = !accept_s && (tmo_cnt_r == TMO_LAST);

    // Deviation of the new sample from the published average and the resulting match run length.
    always_comb begin
        diff_s       = 32'd0;
        match_next_s = '0;
        if (bus.period >= avg_period_r) begin
            diff_s = bus.period - avg_period_r;
        end else begin
            diff_s = avg_period_r - bus.period;
        end
        if (diff_s > TOL_P) begin
            match_next_s = '0;
        end else if (match_count_r == MATCH_FULL) begin
            match_next_s = MATCH_FULL;
        end else begin
            match_next_s = match_count_r + MATCH_ONE;
        end
    end

    // Sample history; stale entries are never read because FILL treats them as zero.
    always_ff @(posedge clock) begin
        if (accept_s) begin
            buf_r[wr_ptr_r] <= bus.period;
        end
    end

    // Fill/run state machine with averaging, lock, reject and timeout bookkeeping.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r        <= ST_FILL;
            wr_ptr_r       <= '0;
            fill_count_r   <= '0;
            sum_r          <= '0;
            match_count_r  <= '0;
            tmo_cnt_r      <= '0;
            avg_valid_r    <= 1'b0;
            avg_period_r   <= 32'd0;
            half_period_r  <= 32'd0;
            locked_r       <= 1'b0;
            timeout_r      <= 1'b0;
            reject_count_r <= 16'd0;
        end else begin
            avg_valid_r <= 1'b0;
            timeout_r   <= 1'b0;
            if (accept_s) begin
                tmo_cnt_r <= '0;
                sum_r     <= sum_next_s;
                wr_ptr_r  <= wr_ptr_r + PTR_ONE;
                case (state_r)
                    ST_FILL: begin
                        fill_count_r  <= fill_count_r + FILL_ONE;
                        match_count_r <= '0;
                        locked_r      <= 1'b0;
                        if (fill_count_r == FILL_LAST) begin
                            state_r       <= ST_RUN;
                            avg_valid_r   <= 1'b1;
                            avg_period_r  <= avg_next_s;
                            half_period_r <= {1'b0, avg_next_s[31:1]};
                        end
                    end
                    ST_RUN: begin
                        avg_valid_r   <= 1'b1;
                        avg_period_r  <= avg_next_s;
                        half_period_r <= {1'b0, avg_next_s[31:1]};
                        match_count_r <= match_next_s;
                        locked_r      <= (match_next_s == MATCH_FULL);
                    end
                    default: begin
                        state_r <= ST_FILL;
                    end
                endcase
            end else begin
                if (bus.period_valid) begin
                    match_count_r <= '0;
                    locked_r      <= 1'b0;
                    if (reject_count_r != 16'hFFFF) begin
                        reject_count_r <= reject_count_r + 16'd1;
                    end
                end
                if (tmo_fire_s) begin
                    // Loss of signal: drop all history and start refilling.
                    timeout_r     <= 1'b1;
                    tmo_cnt_r     <= TMO_DONE;
                    state_r       <= ST_FILL;
                    fill_count_r  <= '0;
                    sum_r         <= '0;
                    wr_ptr_r      <= '0;
                    avg_period_r  <= 32'd0;
                    half_period_r <= 32'd0;
                    locked_r      <= 1'b0;
                    match_count_r <= '0;
                end else if (tmo_cnt_r != TMO_DONE) begin
                    tmo_cnt_r <= tmo_cnt_r + TMO_ONE;
                end
            end
        end
    end

    assign bus.avg_valid    = avg_valid_r;
    assign bus.avg_period   = avg_period_r;
    assign bus.half_period  = half_period_r;
    assign bus.locked       = locked_r;
    assign bus.timeout      = timeout_r;
    assign bus.reject_count = reject_count_r;
endmodule

// File: tb/tb_period_tracker.sv
// Self-checking bench for period_tracker: directed scenarios followed by a
// randomized phase, all checked every cycle against a queue-based model.
module tb_period_tracker;
    localparam int AVG_LOG2       = 3;
    localparam int N              = 1 << AVG_LOG2;
    localparam int MIN_PERIOD     = 32;
    localparam int MAX_PERIOD     = 65535;
    localparam int LOCK_COUNT     = 4;
    localparam int TOL            = 64;
    localparam int TIMEOUT_CYCLES = 4096;

    logic clock = 1'b0;
    logic reset = 1'b1;

    period_tracker_if bus ();

    period_tracker #(
        .AVG_LOG2       (AVG_LOG2),
        .MIN_PERIOD     (MIN_PERIOD),
        .MAX_PERIOD     (MAX_PERIOD),
        .LOCK_COUNT     (LOCK_COUNT),
        .TOL            (TOL),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference state: the accepted samples of the current window, plus counters.
    longint hist[$];
    longint m_avg    = 0;
    int     m_match  = 0;
    int     m_rej    = 0;
    int     m_idle   = 0;
    bit     m_fired  = 1'b0;
    bit     m_valid  = 1'b0;
    bit     m_tmo    = 1'b0;
    bit     m_locked = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic longint window_avg();
        longint s = 0;
        foreach (hist[i]) s += hist[i];
        return s / N;
    endfunction

    // Expected outputs after one clock with the given inputs.
    task automatic model_step(input bit r, input bit v, input longint p);
        bit acc;
        longint dev;
        m_valid = 1'b0;
        m_tmo   = 1'b0;
        if (r) begin
            hist.delete();
            m_avg = 0; m_match = 0; m_rej = 0; m_idle = 0;
            m_fired = 1'b0; m_locked = 1'b0;
            return;
        end
        acc = v && (p >= MIN_PERIOD) && (p <= MAX_PERIOD);
        if (acc) begin
            m_idle  = 0;
            m_fired = 1'b0;
            if (hist.size() == N) begin
                dev = (p > m_avg) ? p - m_avg : m_avg - p;
                if (dev <= TOL) m_match = (m_match < LOCK_COUNT) ? m_match + 1 : LOCK_COUNT;
                else            m_match = 0;
                void'(hist.pop_front());
                hist.push_back(p);
                m_avg   = window_avg();
                m_valid = 1'b1;
            end else begin
                hist.push_back(p);
                if (hist.size() == N) begin
                    m_avg   = window_avg();
                    m_valid = 1'b1;
                end
            end
            m_locked = (m_match == LOCK_COUNT);
        end else begin
            if (v) begin
                if (m_rej < 65535) m_rej++;
                m_match  = 0;
                m_locked = 1'b0;
            end
            if (!m_fired) begin
                m_idle++;
                if (m_idle == TIMEOUT_CYCLES) begin
                    m_fired = 1'b1;
                    m_tmo   = 1'b1;
                    hist.delete();
                    m_avg = 0; m_match = 0; m_locked = 1'b0;
                end
            end
        end
    endtask

    // Drive one cycle of inputs, advance the model, and compare every output.
    task automatic step(input bit r, input bit v, input logic [31:0] p);
        reset            = r;
        bus.period_valid = v;
        bus.period       = p;
        @(posedge clock);
        model_step(r, v, longint'(p));
        @(negedge clock);
        check_eq("avg_valid",    32'(bus.avg_valid),    32'(m_valid));
        check_eq("avg_period",   bus.avg_period,        32'(m_avg));
        check_eq("half_period",  bus.half_period,       32'(m_avg >> 1));
        check_eq("locked",       32'(bus.locked),       32'(m_locked));
        check_eq("timeout",      32'(bus.timeout),      32'(m_tmo));
        check_eq("reject_count", 32'(bus.reject_count), 32'(m_rej));
    endtask

    task automatic spaced(input logic [31:0] p, input int gap);
        step(1'b0, 1'b1, p);
        for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 32'd0);
    endtask

    initial begin
        int n;
        int center;
        int sel;
        logic [31:0] p;
        logic [31:0] edge_vals [4];

        bus.period_valid = 1'b0;
        bus.period       = 32'd0;

        // Reset state.
        step(1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b0, 32'd0);
        check_eq("rst_avg_period",   bus.avg_period,        32'd0);
        check_eq("rst_locked",       32'(bus.locked),       32'd0);
        check_eq("rst_reject_count", 32'(bus.reject_count), 32'd0);

        // Fill with 8 x 1600; only the 8th produces avg_valid.
        for (int i = 0; i < 7; i++) spaced(32'd1600, 19);
        step(1'b0, 1'b1, 32'd1600);
        check_eq("fill_avg_valid", 32'(bus.avg_valid), 32'd1);
        check_eq("fill_avg",       bus.avg_period,      32'd1600);
        check_eq("fill_half",      bus.half_period,     32'd800);
        check_eq("fill_locked",    32'(bus.locked),     32'd0);
        for (int g = 0; g < 19; g++) step(1'b0, 1'b0, 32'd0);

        // Four more in-tolerance samples lock.
        for (int i = 0; i < 3; i++) spaced(32'd1600, 19);
        step(1'b0, 1'b1, 32'd1600);
        check_eq("lock_rise", 32'(bus.locked), 32'd1);
        for (int g = 0; g < 5; g++) step(1'b0, 1'b0, 32'd0);

        // Out-of-range sample while locked.
        step(1'b0, 1'b1, 32'd16);
        check_eq("rej_count",  32'(bus.reject_count), 32'd1);
        check_eq("rej_locked", 32'(bus.locked),       32'd0);
        check_eq("rej_avg",    bus.avg_period,        32'd1600);
        check_eq("rej_valid",  32'(bus.avg_valid),    32'd0);

        // Refresh the window, then a large deviation, then relock near 1610.
        for (int i = 0; i < 8; i++) spaced(32'd1600, 2);
        step(1'b0, 1'b1, 32'd1680);
        check_eq("dev_avg",    bus.avg_period,     32'd1610);
        check_eq("dev_half",   bus.half_period,    32'd805);
        check_eq("dev_locked", 32'(bus.locked),    32'd0);
        for (int i = 0; i < 4; i++) spaced(32'd1610, 1);
        check_eq("relock", 32'(bus.locked), 32'd1);

        // Back-to-back samples at full rate.
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 32'd1605);

        // Idle until loss of signal.
        n = 0;
        for (int i = 1; i <= 5000; i++) begin
            step(1'b0, 1'b0, 32'd0);
            if (bus.timeout === 1'b1) begin
                n = i;
                break;
            end
        end
        check_eq("tmo_delay",  32'(n),              32'd4096);
        check_eq("tmo_avg",    bus.avg_period,      32'd0);
        check_eq("tmo_locked", 32'(bus.locked),     32'd0);
        for (int g = 0; g < 50; g++) step(1'b0, 1'b0, 32'd0);

        // Refill after timeout; no residue from earlier samples.
        for (int i = 0; i < 7; i++) spaced(32'd2000, 3);
        step(1'b0, 1'b1, 32'd2000);
        check_eq("refill_avg", bus.avg_period, 32'd2000);

        // Reset partway through a fill.
        step(1'b1, 1'b0, 32'd0);
        for (int i = 0; i < 5; i++) spaced(32'd1000, 2);
        step(1'b1, 1'b0, 32'd0);
        for (int i = 0; i < 7; i++) spaced(32'd3200, 2);
        step(1'b0, 1'b1, 32'd3200);
        check_eq("mid_rst_avg",   bus.avg_period,        32'd3200);
        check_eq("mid_rst_valid", 32'(bus.avg_valid),    32'd1);
        check_eq("mid_rst_rej",   32'(bus.reject_count), 32'd0);

        // Randomized traffic with boundary values and occasional resets.
        edge_vals[0] = 32'd31;
        edge_vals[1] = 32'd32;
        edge_vals[2] = 32'd65535;
        edge_vals[3] = 32'd65536;
        center = 3200;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 299) == 0) center = 200 + int'($urandom_range(0, 20000));
            if ($urandom_range(0, 999) == 0) begin
                step(1'b1, 1'b0, 32'd0);
            end else if ($urandom_range(0, 99) < 45) begin
                sel = int'($urandom_range(0, 99));
                if (sel < 4)      p = edge_vals[$urandom_range(0, 3)];
                else if (sel < 8) p = (sel < 6) ? 32'($urandom_range(0, 31)) : 32'(65536 + $urandom_range(0, 100000));
                else              p = 32'(center + int'($urandom_range(0, 180)) - 90);
                step(1'b0, 1'b1, p);
            end else begin
                step(1'b0, 1'b0, 32'd0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/period_tracker.md
Name: period_tracker

Overview:
- Sits directly downstream of the 16-phase oversampled frequency counter.
- Consumes its period_valid/period stream, which is in 1/16-clock units.
- Rejects out-of-range periods and keeps a moving average over the last 2^AVG_LOG2 accepted periods.
- Publishes the averaged period and half-period to the drive-timing logic, plus a lock indicator and a loss-of-signal timeout for the feedback controller.

Parameters:
- AVG_LOG2, 3: log2 of the averaging window depth. Default window is 8 samples.
- MIN_PERIOD, 32: smallest accepted period, in 1/16-clock units.
- MAX_PERIOD, 65535: largest accepted period, in 1/16-clock units.
- LOCK_COUNT, 4: number of consecutive in-tolerance samples required to assert locked.
- TOL, 64: maximum allowed |period - avg_period| for a sample to count as in tolerance.
- TIMEOUT_CYCLES, 4096: number of clock cycles without an accepted sample before timeout.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- period_valid  in  1  one-cycle strobe; period is valid in this cycle.
- period  in  32  measured period, 1/16-clock units.
- avg_valid  out  1  one-cycle strobe; avg_period/half_period updated this cycle.
- avg_period  out  32  moving average of accepted periods.
- half_period  out  32  avg_period >> 1.
- locked  out  1  level; stable frequency tracked.
- timeout  out  1  one-cycle strobe on loss of signal.
- reject_count  out  16  saturating count of rejected samples.

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clock.
- Reset:
  - Every output is 0.
  - State = FILL; fill_count = 0; sum = 0; write pointer = 0; match_count = 0; timeout counter = 0.
  - Reset mid-operation discards all history.
- Accept rule: sample accepted iff period_valid && MIN_PERIOD <= period <= MAX_PERIOD.
- Reject path: period_valid with period out of range.
  - reject_count increments, saturating at 16'hFFFF.
  - match_count clears; locked drops in the next cycle.
  - No other state changes; no avg_valid.
- Buffer:
  - Circular store of 2^AVG_LOG2 x 32-bit entries; write pointer wraps modulo depth.
  - sum is 32+AVG_LOG2 bits and never overflows.
  - On accept: sum <= sum + period - oldest, where oldest = 0 while in FILL; the new sample overwrites the oldest entry.
- States:
  - FILL: fill_count counts accepts. The accept that makes fill_count = 2^AVG_LOG2 moves the block to RUN and produces the first avg_valid. Earlier accepts produce no avg_valid.
  - RUN: every accept produces avg_valid.
- Output timing: for a sample presented in cycle k, the following are registered and visible in cycle k+1 with avg_valid high for exactly that cycle:
  - avg_period = (updated sum) >> AVG_LOG2, truncating.
  - half_period = avg_period >> 1.
- Lock (RUN only):
  - Each accepted sample is compared against avg_period before the update.
  - |period - avg_period| <= TOL: match_count increments, saturating at LOCK_COUNT.
  - Otherwise match_count = 0.
  - locked = (match_count == LOCK_COUNT), registered, visible in cycle k+1.
  - Accepts during FILL leave match_count at 0.
- Timeout:
  - Counter clears on every accept and increments each cycle with no accept.
  - When it reaches TIMEOUT_CYCLES, timeout pulses for one cycle and the block returns to FILL: fill_count, sum and pointer clear, buffer contents are treated as zero, and avg_period, half_period, locked and match_count clear.
  - The counter then holds and does not re-fire until after the next accept.
  - reject_count is not cleared by timeout.
  - Rejected samples do not clear the timeout counter.
- Simultaneous events:
  - An accept in the cycle the counter would expire wins: no timeout, counter clears.
  - reset overrides everything.
- period_valid on consecutive cycles must be handled at full rate (one sample per clock).

Test Plan:
- Reset, then 8 accepts of period=1600 spaced 20 cycles apart -> no avg_valid for samples 1-7; avg_valid in the cycle after sample 8 with avg_period=1600 and half_period=800; locked=0.
- Continue with 4 more samples of 1600 -> avg_valid on each; locked rises in the cycle after the 12th sample and stays high.
- While locked, send period=16 -> reject_count=1; locked=0 next cycle; avg_period stays 1600; no avg_valid.
- After 8x1600, send 1680 -> avg_period=1610, half_period=805; deviation 80 > TOL, so match_count=0; next 1610-range samples relock after 4 matches.
- After lock, idle 4096 cycles -> timeout pulses once exactly 4096 cycles after the last accept; avg_period=0 and locked=0; 8 new accepts of 2000 are needed before avg_valid, which then shows avg_period=2000 with no residual 1600 contribution.
- Assert reset after 5 of 8 fill samples, then send 8 samples of 3200 -> first avg_valid follows the 8th post-reset sample with avg_period=3200; reject_count=0.
